// File: rtl/exercise_pkg.sv
// Shared types for the team's buffering blocks.
package exercise_pkg;

   typedef struct packed {
      logic full;
      logic afull;
      logic empty;
      logic aempty;
      logic ovf;
      logic udf;
   } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DWIDTH-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DWIDTH-1:0]        rd_data
);

   logic [DWIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array; a word is only ever read after it was written,
   // and a reset term would stop the array mapping onto RAM. Non-blocking (<=)
   // keeps every register update in this design ordered by the clock edge.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable thresholds, occupancy, flush and sticky error flags.
module fifo_prog
   import exercise_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 8,
   parameter int FWFT   = 1,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [DWIDTH-1:0]      data_i,
   input  logic                   wr,
   output logic                   full_o,
   output logic                   afull_o,
   input  logic                   rd,
   output logic [DWIDTH-1:0]      data_o,
   output logic                   valid_o,
   output logic                   empty_o,
   output logic                   aempty_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   ovf_o,
   output logic                   udf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam bit FWFT_MODE = (FWFT != 0);

   logic [CW-1:0]     wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [CW-1:0]     count, count_d, level_q;
   logic              rd_acc, wr_acc, head_bypass, load_data;
   logic [DWIDTH-1:0] ram_rd_data, next_data, data_q;
   logic              valid_q;
   fifo_status_t      st_q, st_d;

   function automatic fifo_status_t status_of(input logic [CW-1:0] c,
                                              input logic ovf, input logic udf);
      fifo_status_t s;
      s.full   = (c == CW'(DEPTH));
      s.afull  = (c >= CW'(AF_LVL));
      s.empty  = (c == '0);
      s.aempty = (c <= CW'(AE_LVL));
      s.ovf    = ovf;
      s.udf    = udf;
      return s;
   endfunction

   always_comb begin
      count    = wr_ptr - rd_ptr;
      rd_acc   = rd && (count != '0);
      // A read on a full FIFO frees the slot the simultaneous write lands in.
      wr_acc   = wr && ((count != CW'(DEPTH)) || rd_acc);
      wr_ptr_d = wr_ptr + CW'(wr_acc);
      rd_ptr_d = rd_ptr + CW'(rd_acc);
      count_d  = wr_ptr_d - rd_ptr_d;
      st_d     = status_of(count_d, st_q.ovf | (wr & ~wr_acc), st_q.udf | (rd & ~rd_acc));
      // In FWFT the output register tracks the next head; a word written into
      // the slot that becomes the head is taken straight from data_i.
      head_bypass = wr_acc && (rd_ptr_d == wr_ptr);
      load_data   = FWFT_MODE ? (count_d != '0) : rd_acc;
      next_data   = (FWFT_MODE && head_bypass) ? data_i : ram_rd_data;
   end

   fifo_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we      (wr_acc && !clr && !rst),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (data_i),
      .rd_addr (FWFT_MODE ? rd_ptr_d[AW-1:0] : rd_ptr[AW-1:0]),
      .rd_data (ram_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         st_q    <= status_of('0, 1'b0, 1'b0);
         valid_q <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr_d;
         rd_ptr  <= rd_ptr_d;
         level_q <= count_d;
         st_q    <= st_d;
         valid_q <= rd_acc;
      end
   end

   // Flush keeps the last output word; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)                    data_q <= '0;
      else if (!clr && load_data) data_q <= next_data;
   end

   assign data_o   = data_q;
   assign valid_o  = FWFT_MODE ? !st_q.empty : valid_q;
   assign level_o  = level_q;
   assign full_o   = st_q.full;
   assign afull_o  = st_q.afull;
   assign empty_o  = st_q.empty;
   assign aempty_o = st_q.aempty;
   assign ovf_o    = st_q.ovf;
   assign udf_o    = st_q.udf;

endmodule
